// File: rtl/pc_ras_unit.sv
// -----------------------------------------------------------------------------
// pc_ras_unit
// Program counter with a built-in return-address stack (RAS).
//
// One operation is evaluated per rising CLK edge, with fixed priority
//   INTR > CALL > RET > PC_LD > PC_INC > hold.
// Lower-priority requests in the same cycle are ignored.
//
// Ports
//   CLK         in   clock, all state updates on the rising edge
//   RST_N       in   asynchronous active-low reset
//   PC_INC      in   PC <= PC + 1 (wraps at 2^ADDR_W)
//   PC_LD       in   PC <= source chosen by PC_MUX_SEL
//   PC_MUX_SEL  in   0=FROM_IMMED 1=FROM_STACK 2=INTR_VEC 3=RST_VEC
//   FROM_IMMED  in   branch / call target
//   FROM_STACK  in   return address from the external memory stack
//   CALL        in   push PC+1, jump to FROM_IMMED
//   RET         in   pop TOS into PC
//   INTR        in   push PC (unincremented), jump to INTR_VEC
//   PC_COUNT    out  registered current PC
//   STK_DEPTH   out  number of stack entries in use
//   STK_FULL    out  STK_DEPTH == DEPTH
//   STK_EMPTY   out  STK_DEPTH == 0
//   STK_ERR     out  sticky overflow/underflow flag, cleared only by reset
//
// There is no handshake: every request is consumed on the edge it is
// sampled at; there is no back-pressure. The design has no FSM beyond the
// PC, depth and error registers, all of which are visible on the outputs.
// -----------------------------------------------------------------------------
module pc_ras_unit #(
    parameter int                ADDR_W   = 10,
    parameter int                DEPTH    = 8,
    parameter logic [ADDR_W-1:0] RST_VEC  = '0,
    parameter logic [ADDR_W-1:0] INTR_VEC = '1
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         PC_INC,
    input  logic                         PC_LD,
    input  logic [1:0]                   PC_MUX_SEL,
    input  logic [ADDR_W-1:0]            FROM_IMMED,
    input  logic [ADDR_W-1:0]            FROM_STACK,
    input  logic                         CALL,
    input  logic                         RET,
    input  logic                         INTR,
    output logic [ADDR_W-1:0]            PC_COUNT,
    output logic [$clog2(DEPTH+1)-1:0]   STK_DEPTH,
    output logic                         STK_FULL,
    output logic                         STK_EMPTY,
    output logic                         STK_ERR
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_next;
    logic [DW-1:0]     depth_q, depth_next;
    logic              err_q, err_next;

    logic              push_en;
    logic [ADDR_W-1:0] push_data;
    logic [IW-1:0]     push_idx;
    logic [IW-1:0]     tos_idx;
    logic [ADDR_W-1:0] tos;
    logic [ADDR_W-1:0] pc_plus1;

    // Entries are not reset and are never cleared on pop: only the depth
    // register decides which entries are live.
    logic [ADDR_W-1:0] stk [DEPTH];

    assign STK_FULL  = (depth_q == DW'(DEPTH));
    assign STK_EMPTY = (depth_q == '0);

    assign pc_plus1 = pc_q + 1'b1;
    assign push_idx = IW'(depth_q);
    // Only meaningful when the stack is non-empty; RET on empty never reads it.
    assign tos_idx  = IW'(depth_q - 1'b1);
    assign tos      = stk[tos_idx];

    always_comb begin
        pc_next    = pc_q;
        depth_next = depth_q;
        err_next   = err_q;
        push_en    = 1'b0;
        push_data  = pc_q;

        if (INTR) begin
            // The jump always happens; only the push is dropped on overflow.
            pc_next = INTR_VEC;
            if (!STK_FULL) begin
                push_en    = 1'b1;
                push_data  = pc_q;
                depth_next = depth_q + 1'b1;
            end else begin
                err_next = 1'b1;
            end
        end else if (CALL) begin
            pc_next = FROM_IMMED;
            if (!STK_FULL) begin
                push_en    = 1'b1;
                push_data  = pc_plus1;
                depth_next = depth_q + 1'b1;
            end else begin
                err_next = 1'b1;
            end
        end else if (RET) begin
            // Underflow holds the PC rather than jumping to a stale entry.
            if (!STK_EMPTY) begin
                pc_next    = tos;
                depth_next = depth_q - 1'b1;
            end else begin
                err_next = 1'b1;
            end
        end else if (PC_LD) begin
            unique case (PC_MUX_SEL)
                2'd0:    pc_next = FROM_IMMED;
                2'd1:    pc_next = FROM_STACK;
                2'd2:    pc_next = INTR_VEC;
                default: pc_next = RST_VEC;
            endcase
        end else if (PC_INC) begin
            pc_next = pc_plus1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pc_q    <= RST_VEC;
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            pc_q    <= pc_next;
            depth_q <= depth_next;
            err_q   <= err_next;
        end
    end

    // A write left behind by an aborted push lands above the reset depth of
    // zero, so it is never observable.
    always_ff @(posedge CLK) begin
        if (push_en) begin
            stk[push_idx] <= push_data;
        end
    end

    assign PC_COUNT  = pc_q;
    assign STK_DEPTH = depth_q;
    assign STK_ERR   = err_q;

endmodule

// File: tb/tb_pc_ras_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_ras_unit
// Self-checking bench for pc_ras_unit with ADDR_W=10, DEPTH=4.
// Table of {inputs, expected outputs} applied in a loop, hand-written
// async-reset sequences, then a randomised phase checked against a small
// reference model. Expected outputs flow through a scoreboard queue.
// -----------------------------------------------------------------------------
module tb_pc_ras_unit;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 4;
    localparam int DW     = 3;
    localparam int EW     = ADDR_W + DW + 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              pc_inc, pc_ld, call, ret, intr;
    logic [1:0]        pc_mux_sel;
    logic [ADDR_W-1:0] from_immed, from_stack;
    logic [ADDR_W-1:0] pc_count;
    logic [DW-1:0]     stk_depth;
    logic              stk_full, stk_empty, stk_err;

    pc_ras_unit #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .PC_INC     (pc_inc),
        .PC_LD      (pc_ld),
        .PC_MUX_SEL (pc_mux_sel),
        .FROM_IMMED (from_immed),
        .FROM_STACK (from_stack),
        .CALL       (call),
        .RET        (ret),
        .INTR       (intr),
        .PC_COUNT   (pc_count),
        .STK_DEPTH  (stk_depth),
        .STK_FULL   (stk_full),
        .STK_EMPTY  (stk_empty),
        .STK_ERR    (stk_err)
    );

    // ---------------- vectors ----------------
    typedef struct {
        string             name;
        logic              intr, call, ret, ld, inc;
        logic [1:0]        sel;
        logic [ADDR_W-1:0] immed, stack;
        logic [ADDR_W-1:0] exp_pc;
        logic [DW-1:0]     exp_depth;
        logic              exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic i, logic c, logic r, logic l,
                                logic n, logic [1:0] s, logic [ADDR_W-1:0] im,
                                logic [ADDR_W-1:0] st, logic [ADDR_W-1:0] epc,
                                logic [DW-1:0] ed, logic ee);
        vec_t v;
        v.name = name; v.intr = i; v.call = c; v.ret = r; v.ld = l; v.inc = n;
        v.sel = s; v.immed = im; v.stack = st;
        v.exp_pc = epc; v.exp_depth = ed; v.exp_err = ee;
        return v;
    endfunction

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [EW-1:0] pack_exp(logic [ADDR_W-1:0] pc,
                                               logic [DW-1:0] d, logic e);
        return {pc, d, (d == DW'(DEPTH)), (d == '0), e};
    endfunction

    task automatic expect_out(logic [ADDR_W-1:0] pc, logic [DW-1:0] d, logic e);
        exp_q.push_back(pack_exp(pc, d, e));
    endtask

    task automatic sample(string name);
        logic [EW-1:0] act, exp;
        act = {pc_count, stk_depth, stk_full, stk_empty, stk_err};
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, got %h", name, act);
        end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
                n_fail++;
                $display("FAIL %s: got pc=%h depth=%0d full=%b empty=%b err=%b, want pc=%h depth=%0d full=%b empty=%b err=%b",
                         name, act[EW-1 -: ADDR_W], act[5:3], act[2], act[1], act[0],
                         exp[EW-1 -: ADDR_W], exp[5:3], exp[2], exp[1], exp[0]);
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(vec_t v);
        intr = v.intr; call = v.call; ret = v.ret; pc_ld = v.ld; pc_inc = v.inc;
        pc_mux_sel = v.sel; from_immed = v.immed; from_stack = v.stack;
    endtask

    task automatic idle();
        intr = 0; call = 0; ret = 0; pc_ld = 0; pc_inc = 0;
        pc_mux_sel = 0; from_immed = 0; from_stack = 0;
    endtask

    task automatic apply(vec_t v);
        drive(v);
        expect_out(v.exp_pc, v.exp_depth, v.exp_err);
        @(posedge clk);
        #1;
        sample(v.name);
    endtask

    // ---------------- reference model for random phase ----------------
    logic [ADDR_W-1:0] m_pc;
    logic [DW-1:0]     m_depth;
    logic              m_err;
    logic [ADDR_W-1:0] m_stk [DEPTH];

    task automatic model_step(vec_t v);
        if (v.intr) begin
            if (m_depth < DW'(DEPTH)) begin
                m_stk[m_depth] = m_pc; m_depth = m_depth + 1;
            end else m_err = 1;
            m_pc = '1;
        end else if (v.call) begin
            if (m_depth < DW'(DEPTH)) begin
                m_stk[m_depth] = m_pc + 10'd1; m_depth = m_depth + 1;
            end else m_err = 1;
            m_pc = v.immed;
        end else if (v.ret) begin
            if (m_depth > 0) begin
                m_depth = m_depth - 1; m_pc = m_stk[m_depth];
            end else m_err = 1;
        end else if (v.ld) begin
            case (v.sel)
                2'd0: m_pc = v.immed;
                2'd1: m_pc = v.stack;
                2'd2: m_pc = '1;
                default: m_pc = '0;
            endcase
        end else if (v.inc) begin
            m_pc = m_pc + 10'd1;
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // ---------------- test ----------------
    initial begin
        vec_t v;
        idle();

        //            name          intr call ret ld inc sel immed   stack   exp_pc  d  err
        vecs.push_back(mk("inc1",      0, 0, 0, 0, 1, 0, 10'h000, 10'h000, 10'h001, 0, 0));
        vecs.push_back(mk("inc2",      0, 0, 0, 0, 1, 0, 10'h000, 10'h000, 10'h002, 0, 0));
        vecs.push_back(mk("inc3",      0, 0, 0, 0, 1, 0, 10'h000, 10'h000, 10'h003, 0, 0));
        vecs.push_back(mk("ld_immed",  0, 0, 0, 1, 0, 0, 10'h003, 10'h002, 10'h003, 0, 0));
        vecs.push_back(mk("ld_stack",  0, 0, 0, 1, 0, 1, 10'h003, 10'h002, 10'h002, 0, 0));
        vecs.push_back(mk("ld_intr",   0, 0, 0, 1, 0, 2, 10'h003, 10'h002, 10'h3FF, 0, 0));
        vecs.push_back(mk("ld_rst",    0, 0, 0, 1, 0, 3, 10'h003, 10'h002, 10'h000, 0, 0));
        vecs.push_back(mk("ld_max",    0, 0, 0, 1, 0, 2, 10'h000, 10'h000, 10'h3FF, 0, 0));
        vecs.push_back(mk("inc_wrap",  0, 0, 0, 0, 1, 0, 10'h000, 10'h000, 10'h000, 0, 0));
        vecs.push_back(mk("ld_010",    0, 0, 0, 1, 0, 0, 10'h010, 10'h000, 10'h010, 0, 0));
        vecs.push_back(mk("call_100",  0, 1, 0, 0, 0, 0, 10'h100, 10'h000, 10'h100, 1, 0));
        vecs.push_back(mk("call_200",  0, 1, 0, 0, 0, 0, 10'h200, 10'h000, 10'h200, 2, 0));
        vecs.push_back(mk("ret_101",   0, 0, 1, 0, 0, 0, 10'h000, 10'h000, 10'h101, 1, 0));
        vecs.push_back(mk("ret_011",   0, 0, 1, 0, 0, 0, 10'h000, 10'h000, 10'h011, 0, 0));
        vecs.push_back(mk("ld_020",    0, 0, 0, 1, 0, 0, 10'h020, 10'h000, 10'h020, 0, 0));
        vecs.push_back(mk("intr_prio", 1, 1, 0, 0, 1, 0, 10'h155, 10'h000, 10'h3FF, 1, 0));
        vecs.push_back(mk("ret_tos",   0, 0, 1, 0, 0, 0, 10'h000, 10'h000, 10'h020, 0, 0));
        vecs.push_back(mk("call_ret",  0, 1, 1, 0, 0, 0, 10'h050, 10'h000, 10'h050, 1, 0));
        vecs.push_back(mk("ret_ld_inc",0, 0, 1, 1, 1, 0, 10'h1AA, 10'h000, 10'h021, 0, 0));
        vecs.push_back(mk("ov_call1",  0, 1, 0, 0, 0, 0, 10'h0A0, 10'h000, 10'h0A0, 1, 0));
        vecs.push_back(mk("ov_call2",  0, 1, 0, 0, 0, 0, 10'h0B0, 10'h000, 10'h0B0, 2, 0));
        vecs.push_back(mk("ov_call3",  0, 1, 0, 0, 0, 0, 10'h0C0, 10'h000, 10'h0C0, 3, 0));
        vecs.push_back(mk("ov_call4",  0, 1, 0, 0, 0, 0, 10'h0D0, 10'h000, 10'h0D0, 4, 0));
        vecs.push_back(mk("ov_call5",  0, 1, 0, 0, 0, 0, 10'h0E0, 10'h000, 10'h0E0, 4, 1));
        vecs.push_back(mk("un_ret1",   0, 0, 1, 0, 0, 0, 10'h000, 10'h000, 10'h0C1, 3, 1));
        vecs.push_back(mk("un_ret2",   0, 0, 1, 0, 0, 0, 10'h000, 10'h000, 10'h0B1, 2, 1));
        vecs.push_back(mk("un_ret3",   0, 0, 1, 0, 0, 0, 10'h000, 10'h000, 10'h0A1, 1, 1));
        vecs.push_back(mk("un_ret4",   0, 0, 1, 0, 0, 0, 10'h000, 10'h000, 10'h022, 0, 1));
        vecs.push_back(mk("un_ret5",   0, 0, 1, 0, 0, 0, 10'h000, 10'h000, 10'h022, 0, 1));
        vecs.push_back(mk("err_stick", 0, 0, 0, 0, 1, 0, 10'h000, 10'h000, 10'h023, 0, 1));

        // Reset state, held across edges.
        repeat (2) @(posedge clk);
        #1;
        expect_out(10'h000, 0, 0);
        sample("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) apply(vecs[i]);

        // Async reset clears the sticky error, without any clock edge.
        #2 rst_n = 1'b0;
        #1;
        expect_out(10'h000, 0, 0);
        sample("rst_clears_err");
        #1 rst_n = 1'b1;

        // Build depth 3, then pulse reset between edges with a CALL pending.
        apply(mk("mid_call1", 0, 1, 0, 0, 0, 0, 10'h100, 0, 10'h100, 1, 0));
        apply(mk("mid_call2", 0, 1, 0, 0, 0, 0, 10'h200, 0, 10'h200, 2, 0));
        apply(mk("mid_call3", 0, 1, 0, 0, 0, 0, 10'h300, 0, 10'h300, 3, 0));
        v = mk("post_rst_call", 0, 1, 0, 0, 0, 0, 10'h155, 0, 10'h155, 1, 0);
        drive(v);
        #2 rst_n = 1'b0;
        #1;
        expect_out(10'h000, 0, 0);
        sample("async_rst_mid");
        #1 rst_n = 1'b1;
        // First edge after release honours the pending CALL from PC 0.
        apply(v);
        apply(mk("post_rst_ret", 0, 0, 1, 0, 0, 0, 0, 0, 10'h001, 0, 0));

        // INTR overflow: jump still happens, push dropped.
        apply(mk("intr_push1", 1, 0, 0, 0, 0, 0, 0, 0, 10'h3FF, 1, 0));
        apply(mk("ld_040",     0, 0, 0, 1, 0, 0, 10'h040, 0, 10'h040, 1, 0));
        apply(mk("intr_push2", 1, 0, 0, 0, 0, 0, 0, 0, 10'h3FF, 2, 0));
        apply(mk("intr_push3", 1, 0, 0, 0, 0, 0, 0, 0, 10'h3FF, 3, 0));
        apply(mk("intr_push4", 1, 0, 0, 0, 0, 0, 0, 0, 10'h3FF, 4, 0));
        apply(mk("ld_077",     0, 0, 0, 1, 0, 0, 10'h077, 0, 10'h077, 4, 0));
        apply(mk("intr_ovf",   1, 0, 0, 0, 0, 0, 0, 0, 10'h3FF, 4, 1));
        apply(mk("ret_after_ovf", 0, 0, 1, 0, 0, 0, 0, 0, 10'h3FF, 3, 1));

        // Random phase against the reference model, from a fresh reset.
        @(negedge clk);
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        m_pc = '0; m_depth = '0; m_err = 1'b0;
        for (int i = 0; i < 80; i++) begin
            v.name  = $sformatf("rand%0d", i);
            v.intr  = ($urandom_range(0, 9) == 0);
            v.call  = ($urandom_range(0, 3) == 0);
            v.ret   = ($urandom_range(0, 3) == 0);
            v.ld    = ($urandom_range(0, 3) == 0);
            v.inc   = ($urandom_range(0, 1) == 0);
            v.sel   = 2'($urandom_range(0, 3));
            v.immed = ADDR_W'($urandom_range(0, 1023));
            v.stack = ADDR_W'($urandom_range(0, 1023));
            model_step(v);
            v.exp_pc = m_pc; v.exp_depth = m_depth; v.exp_err = m_err;
            apply(v);
        end

        idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_ras_unit.md
PC_RAS_UNIT -- requirements
Module: pc_ras_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, which sets the program-counter width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, which sets the number of return-address stack entries; legal values are 2..64.
REQ-003 SHALL have parameter RST_VEC, default 0, which is the PC value loaded on reset.
REQ-004 SHALL have parameter INTR_VEC, default all-ones, which is the interrupt vector address.
REQ-005 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port RST_N, input, 1 bit: the reset; it is asynchronous and active-low.
REQ-007 SHALL have port PC_INC, input, 1 bit: increment the PC.
REQ-008 SHALL have port PC_LD, input, 1 bit: load the PC from the source selected by PC_MUX_SEL.
REQ-009 SHALL have port PC_MUX_SEL, input, 2 bits: load source select; 0=FROM_IMMED, 1=FROM_STACK, 2=INTR_VEC, 3=RST_VEC.
REQ-010 SHALL have port FROM_IMMED, input, ADDR_W bits: immediate branch or call target.
REQ-011 SHALL have port FROM_STACK, input, ADDR_W bits: return address supplied from the external memory stack.
REQ-012 SHALL have port CALL, input, 1 bit: push PC_COUNT+1 onto the stack and jump to FROM_IMMED.
REQ-013 SHALL have port RET, input, 1 bit: pop the top of stack (TOS) into the PC.
REQ-014 SHALL have port INTR, input, 1 bit: push PC_COUNT onto the stack and jump to INTR_VEC.
REQ-015 SHALL have port PC_COUNT, output, ADDR_W bits: the registered current PC.
REQ-016 SHALL have port STK_DEPTH, output, clog2(DEPTH+1) bits: current number of stack entries.
REQ-017 SHALL have port STK_FULL, output, 1 bit: asserted when STK_DEPTH==DEPTH.
REQ-018 SHALL have port STK_EMPTY, output, 1 bit: asserted when STK_DEPTH==0.
REQ-019 SHALL have port STK_ERR, output, 1 bit: sticky overflow/underflow flag.

Function
REQ-020 SHALL evaluate one operation per rising CLK edge, with priority INTR > CALL > RET > PC_LD > PC_INC > hold; lower-priority requests in the same cycle are ignored.
REQ-021 SHALL present every PC update on PC_COUNT one cycle after the request (registered output, no combinational path from inputs).
REQ-022 SHALL, on PC_INC, set PC to PC_COUNT+1 modulo 2^ADDR_W; at all-ones it wraps to 0 with no flag.
REQ-023 SHALL, on PC_LD, load the PC_MUX_SEL source; the stack is unaffected.
REQ-024 SHALL, on CALL when not full: write PC_COUNT+1 (wrapped) to entry STK_DEPTH, increment the depth, and load FROM_IMMED.
REQ-025 SHALL, on INTR when not full: push PC_COUNT unincremented, increment the depth, and load INTR_VEC.
REQ-026 SHALL, on RET when not empty: load TOS into the PC and decrement the depth.
REQ-027 SHALL, on CALL or INTR when full: still perform the jump, drop the push, leave the depth and all entries unchanged, and set STK_ERR.
REQ-028 SHALL, on RET when empty: hold the PC, leave the depth at 0, and set STK_ERR.
REQ-029 SHALL, once STK_ERR is set, hold it until reset; no input clears it.
REQ-030 SHALL derive STK_FULL and STK_EMPTY combinationally from the registered depth only.
REQ-031 SHALL store stack entries in a register array indexed by depth; a pop does not clear the entry.
REQ-032 SHALL, when CALL and RET arrive in the same cycle, perform CALL only.

Reset
REQ-033 SHALL, while RST_N is low, asynchronously force PC_COUNT=RST_VEC, STK_DEPTH=0, STK_EMPTY=1, STK_FULL=0, STK_ERR=0; stack entry contents are don't-care.
REQ-034 SHALL, when RST_N asserts mid-operation, discard any in-progress push or pop; no partial update is visible after release.
REQ-035 SHALL honour the first operation on the first rising CLK edge after RST_N deasserts.

Verification (ADDR_W=10, DEPTH=4)
REQ-036 SHALL cover reset then increment: RST_N low, then PC_INC for 3 cycles -> PC_COUNT 0,1,2,3; with PC_COUNT=0x3FF, PC_INC -> 0x000.
REQ-037 SHALL cover the load mux: PC_LD with SEL 0..3, FROM_IMMED=3, FROM_STACK=2 -> PC_COUNT 3, 2, 0x3FF, 0 on successive cycles.
REQ-038 SHALL cover nested calls: PC=0x010, CALL to 0x100, CALL to 0x200, RET, RET -> PC 0x100, 0x200, 0x101, 0x011; depth 1,2,1,0.
REQ-039 SHALL cover overflow and underflow: 5 CALLs -> depth stays 4, STK_FULL=1, STK_ERR=1, 5th target still loaded; then 5 RETs -> 4 pops, the 5th holds PC, STK_ERR remains 1.
REQ-040 SHALL cover interrupt priority: INTR+CALL+PC_INC at PC=0x020 -> PC=0x3FF, TOS=0x020, depth+1.
REQ-041 SHALL cover async reset mid-stream: RST_N pulsed low between edges at depth 3 -> outputs reach reset values immediately, before the next CLK edge.
